// File: rtl/motion_pkg.sv
// Shared definitions for the motion-mask pipeline: mask byte codes, default
// frame geometry and the read/write handshake state type.
package motion_pkg;

  localparam int DEF_WIDTH  = 720;
  localparam int DEF_HEIGHT = 540;

  localparam logic [7:0] MASK_MOTION = 8'h00;
  localparam logic [7:0] MASK_STATIC = 8'hFF;

  // Two legal codes in a 2-bit encoding so an upset can be caught and recovered.
  typedef enum logic [1:0] {
    S0 = 2'b00,  // read: pop one mask byte and one pixel together
    S1 = 2'b01   // write: push the registered pixel downstream
  } rw_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_motion(input logic [7:0] mask);
    return mask == MASK_MOTION;
  endfunction

endpackage

// File: rtl/motion_highlight_pixel_counter.sv
// Raster position counter: col/row advance by one pixel per advance pulse,
// last_pixel marks the final pixel of the frame.
module pixel_counter
  import motion_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  localparam int COL_W = cnt_w(WIDTH),
  localparam int ROW_W = cnt_w(HEIGHT)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_col,
  output logic             last_pixel
);

  assign last_col   = (col == COL_W'(WIDTH - 1));
  assign last_pixel = last_col && (row == ROW_W'(HEIGHT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (last_col) begin
        col <= '0;
        row <= last_pixel ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/motion_highlight.sv
// Replaces motion pixels with a highlight colour, tracks raster position and
// pulses frame_done on the last write. MOTION_COUNT_EN adds a per-frame motion count.
module motion_highlight
  import motion_pkg::*;
#(
  parameter int          WIDTH           = DEF_WIDTH,
  parameter int          HEIGHT          = DEF_HEIGHT,
  parameter logic [23:0] HIGHLIGHT_COLOR = 24'hFF0000
`ifdef MOTION_COUNT_EN
  ,
  localparam int COUNT_W = $clog2(WIDTH * HEIGHT + 1)
`endif
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mask_rd_en,
  input  logic        mask_empty,
  input  logic [7:0]  mask_dout,
  output logic        img_in_rd_en,
  input  logic        img_in_empty,
  input  logic [23:0] img_in_dout,
  output logic        img_out_wr_en,
  input  logic        img_out_full,
  output logic [23:0] img_out_din,
  output logic        frame_done
`ifdef MOTION_COUNT_EN
  ,
  output logic [COUNT_W-1:0] motion_count
`endif
);

  localparam int COL_W = cnt_w(WIDTH);
  localparam int ROW_W = cnt_w(HEIGHT);

  rw_state_t        state_q, state_d;
  logic [23:0]      pix_q;
  logic             load, advance;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last_col, last_pixel;
  logic             unused_pos;

  pixel_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_pos (
    .clock      (clock),
    .reset      (reset),
    .advance    (advance),
    .col        (col),
    .row        (row),
    .last_col   (last_col),
    .last_pixel (last_pixel)
  );

  // Position is only consumed through last_pixel here.
  assign unused_pos = ^{col, row, last_col};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mask_rd_en    = 1'b0;
    img_in_rd_en  = 1'b0;
    img_out_wr_en = 1'b0;
    img_out_din   = 24'h0;
    frame_done    = 1'b0;
    load          = 1'b0;
    advance       = 1'b0;
    case (state_q)
      S0: if (!mask_empty && !img_in_empty) begin
        mask_rd_en   = 1'b1;
        img_in_rd_en = 1'b1;
        load         = 1'b1;
        state_d      = S1;
      end
      S1: if (!img_out_full) begin
        img_out_wr_en = 1'b1;
        img_out_din   = pix_q;
        advance       = 1'b1;
        frame_done    = last_pixel;
        state_d       = S0;
      end
      default: state_d = S0;
    endcase
    // Async reset forces S0, but S0 would still pop if the FIFOs are non-empty.
    if (reset) begin
      mask_rd_en   = 1'b0;
      img_in_rd_en = 1'b0;
      load         = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     pix_q <= 24'h0;
    else if (load) pix_q <= is_motion(mask_dout) ? HIGHLIGHT_COLOR : img_in_dout;
  end

`ifdef MOTION_COUNT_EN
  logic               mot_q;
  logic [COUNT_W-1:0] running_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     mot_q <= 1'b0;
    else if (load) mot_q <= is_motion(mask_dout);
  end

  // The frame's last pixel is folded in as the count is published.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      running_q    <= '0;
      motion_count <= '0;
    end else if (advance) begin
      if (last_pixel) begin
        motion_count <= running_q + COUNT_W'(mot_q);
        running_q    <= '0;
      end else begin
        running_q    <= running_q + COUNT_W'(mot_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_motion_highlight.sv
// Self-checking bench for motion_highlight (WIDTH=4, HEIGHT=2): FIFO models,
// pop-time scoreboard and directed plus randomized traffic.
module tb_motion_highlight;

  localparam int          W  = 4;
  localparam int          H  = 2;
  localparam int          FR = W * H;
  localparam logic [23:0] HL = 24'hFF0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mask_rd_en, img_in_rd_en, img_out_wr_en, frame_done;
  logic        mask_empty = 1'b1, img_in_empty = 1'b1, img_out_full = 1'b0;
  logic [7:0]  mask_dout = 8'h0;
  logic [23:0] img_in_dout = 24'h0;
  logic [23:0] img_out_din;
`ifdef MOTION_COUNT_EN
  logic [3:0]  motion_count;
`endif

  motion_highlight #(.WIDTH(W), .HEIGHT(H), .HIGHLIGHT_COLOR(HL)) dut (
    .clock         (clock),
    .reset         (reset),
    .mask_rd_en    (mask_rd_en),
    .mask_empty    (mask_empty),
    .mask_dout     (mask_dout),
    .img_in_rd_en  (img_in_rd_en),
    .img_in_empty  (img_in_empty),
    .img_in_dout   (img_in_dout),
    .img_out_wr_en (img_out_wr_en),
    .img_out_full  (img_out_full),
    .img_out_din   (img_out_din),
    .frame_done    (frame_done)
`ifdef MOTION_COUNT_EN
    ,
    .motion_count  (motion_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [23:0] pix; logic mot; } exp_t;

  logic [7:0]  mq[$];
  logic [23:0] iq[$];
  logic [23:0] outq[$];
  exp_t        eq[$];
  exp_t        e;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, wr_total = 0, pops = 0, wr_since_rst = 0;
  int frame_mot = 0, exp_mc = 0, last_wr = -1;
  bit gap_chk = 0, rand_full = 0, force_full = 0;
  bit pop_m = 0, pop_i = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] m, input logic [23:0] p);
    mq.push_back(m);
    iq.push_back(p);
  endtask

  function automatic logic [7:0] rand_mask();
    int k = $urandom_range(0, 2);
    if (k == 0) return 8'h00;
    if (k == 1) return 8'hFF;
    return 8'($urandom);
  endfunction

  task automatic wait_wr(input int target, input int budget, input string tag);
    int n = 0;
    while (wr_total < target && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (wr_total < target) chk(tag, wr_total, target);
  endtask

  // FIFO models: pop what the DUT strobed, then present the new heads.
  always @(posedge clock) begin
    cyc++;
    #1;
    if (pop_m && mq.size() > 0) void'(mq.pop_front());
    if (pop_i && iq.size() > 0) void'(iq.pop_front());
    mask_empty   = (mq.size() == 0);
    img_in_empty = (iq.size() == 0);
    mask_dout    = (mq.size() > 0) ? mq[0] : 8'h0;
    img_in_dout  = (iq.size() > 0) ? iq[0] : 24'h0;
    img_out_full = rand_full ? ($urandom_range(0, 2) == 0) : force_full;
  end

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge clock) begin
    pop_m = mask_rd_en;
    pop_i = img_in_rd_en;
    if (reset) begin
      eq.delete();
      wr_since_rst = 0;
      frame_mot    = 0;
      exp_mc       = 0;
      chk("rst_quiet", {31'b0, mask_rd_en | img_in_rd_en | img_out_wr_en | frame_done | (|img_out_din)}, 0);
    end
    chk("rd_pair", {31'b0, mask_rd_en}, {31'b0, img_in_rd_en});
    chk("rd_when_empty", {31'b0, mask_rd_en & (mask_empty | img_in_empty)}, 0);
`ifdef MOTION_COUNT_EN
    chk("motion_count", {28'b0, motion_count}, exp_mc);
`endif
    if (img_out_wr_en) begin
      chk("wr_full", {31'b0, img_out_full}, 0);
      outq.push_back(img_out_din);
      if (eq.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        e = eq.pop_front();
        chk("pixel", {8'b0, img_out_din}, {8'b0, e.pix});
        wr_since_rst++;
        wr_total++;
        chk("frame_done", {31'b0, frame_done}, {31'b0, (wr_since_rst % FR) == 0});
        frame_mot += int'(e.mot);
        if (wr_since_rst % FR == 0) begin
          exp_mc    = frame_mot;
          frame_mot = 0;
        end
      end
      if (gap_chk && last_wr >= 0) chk("gap", cyc - last_wr, 2);
      last_wr = cyc;
    end else begin
      chk("idle_din", {8'b0, img_out_din}, 0);
      chk("idle_fd", {31'b0, frame_done}, 0);
    end
    if (mask_rd_en) begin
      pops++;
      eq.push_back('{pix: (mask_dout == 8'h00) ? HL : img_in_dout, mot: (mask_dout == 8'h00)});
    end
  end

  initial begin
    logic [23:0] basic_exp [4];
    int p0, w0;
    basic_exp = '{24'hFF0000, 24'hABCDEF, 24'hFF0000, 24'hFFFFFF};

    // Basic substitution, with data already waiting while reset is held.
    push(8'h00, 24'h123456);
    push(8'hFF, 24'hABCDEF);
    push(8'h00, 24'h000001);
    push(8'hFF, 24'hFFFFFF);
    repeat (3) @(posedge clock);
    #2;
    chk("rst_mask_rd", {31'b0, mask_rd_en}, 0);
    chk("rst_img_rd", {31'b0, img_in_rd_en}, 0);
    chk("rst_din", {8'b0, img_out_din}, 0);
    gap_chk = 1;
    reset   = 1'b0;
    wait_wr(4, 40, "basic_timeout");
    gap_chk = 0;
    for (int i = 0; i < 4; i++)
      chk("basic_out", (outq.size() > i) ? {8'b0, outq[i]} : 32'hDEAD, {8'b0, basic_exp[i]});

    // Empty skew: pixels present, masks absent.
    iq.push_back(24'h111111);
    iq.push_back(24'h222222);
    iq.push_back(24'h333333);
    p0 = pops;
    repeat (10) @(posedge clock);
    chk("skew_nopop", pops - p0, 0);
    mq.push_back(8'hFF);
    mq.push_back(8'h00);
    mq.push_back(8'h5A);
    wait_wr(7, 40, "skew_timeout");

    // Backpressure while holding a pixel in the write state.
    force_full = 1;
    push(8'h7E, 24'hC0FFEE);
    push(8'h00, 24'h0BADF0);
    repeat (3) @(posedge clock);
    p0 = pops;
    w0 = wr_total;
    repeat (5) @(posedge clock);
    #2;
    chk("bp_nopop", pops - p0, 0);
    chk("bp_nowrite", wr_total - w0, 0);
    chk("bp_din", {8'b0, img_out_din}, 0);
    force_full = 0;
    wait_wr(9, 40, "bp_timeout");

    // Frame boundary: complete the second frame.
    for (int i = 0; i < 7; i++) push(rand_mask(), 24'($urandom));
    wait_wr(16, 80, "frame_timeout");

    // Reset after the fifth write of a frame.
    for (int i = 0; i < 12; i++) push(rand_mask(), 24'($urandom));
    wait_wr(21, 80, "pre_rst_timeout");
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_wr", {31'b0, img_out_wr_en | mask_rd_en | img_in_rd_en}, 0);
    chk("mid_rst_din", {8'b0, img_out_din}, 0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    push(rand_mask(), 24'($urandom));
    wait_wr(29, 80, "post_rst_timeout");
    chk("post_rst_drain", mq.size(), 0);

    // Frame with three motion pixels, then a frame with none.
    push(8'h00, 24'h000010); push(8'hFF, 24'h000020);
    push(8'h00, 24'h000030); push(8'h11, 24'h000040);
    push(8'hFF, 24'h000050); push(8'h00, 24'h000060);
    push(8'hFF, 24'h000070); push(8'hFF, 24'h000080);
    wait_wr(37, 80, "mc3_timeout");
    #2;
`ifdef MOTION_COUNT_EN
    chk("mc_three", {28'b0, motion_count}, 3);
`endif
    for (int i = 0; i < FR; i++) push(8'h01 + 8'(i), 24'h100000 + 24'(i));
    wait_wr(41, 80, "mc_mid_timeout");
    #2;
`ifdef MOTION_COUNT_EN
    chk("mc_hold", {28'b0, motion_count}, 3);
`endif
    wait_wr(45, 80, "mc0_timeout");
    #2;
`ifdef MOTION_COUNT_EN
    chk("mc_zero", {28'b0, motion_count}, 0);
`endif

    // Randomized traffic with random output backpressure.
    rand_full = 1;
    for (int i = 0; i < 48; i++) begin
      push(rand_mask(), 24'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clock);
    end
    wait_wr(93, 2000, "rand_timeout");
    rand_full = 0;
    repeat (4) @(posedge clock);
    chk("final_drain", eq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
